// File: rtl/regwr_arbiter.sv
// ============================================================================
// regwr_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares the register file's single write port between the pipeline
//   writeback stage (WB) and a long-latency unit (LU: divider, multi-cycle
//   load).
//   - WB has priority and is never back-pressured. Its write is granted in
//     the same cycle it is requested, except during a one-cycle FORCE drain,
//     when the pipeline is frozen through stall_req.
//   - LU results arrive over a valid/ready handshake. They are written
//     straight through when the port is idle and the buffer is empty.
//     Otherwise they are held in a DEPTH-entry FIFO and drained whenever WB
//     leaves the port free.
//   - A starvation guard counts the cycles in which the FIFO head is denied
//     the port. When the count would reach STARVE_MAX, the next cycle becomes
//     a FORCE cycle. In that cycle the pipeline is stalled and the head is
//     written.
//   - Writes to register 0 are never issued. LU results aimed at r0 are
//     accepted and dropped.
//
// Configuration macro:
//   REGWR_PEND_BYPASS_EN - when defined, two combinational lookup ports
//                          report whether the FIFO holds a pending result
//                          for a given register. The newest matching
//                          entry's data is returned. When the macro is
//                          undefined, the lookup outputs are tied to 0.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wb_we/waddr/wdata   WB write request (highest priority)
//   lu_valid/waddr/wdata, lu_ready
//                       LU result handshake
//   stall_req           registered; high for the single FORCE cycle
//   rf_we/waddr/wdata   register file write port
//   pend_cnt            FIFO occupancy
//   chk_addr1/2         register addresses to look up in the FIFO
//   pend_hit1/2         a pending entry matches chk_addrN (bypass build)
//   pend_data1/2        newest matching entry's data (bypass build)
// ============================================================================
module regwr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // writeback stage
    input  logic                         wb_we,
    input  logic [ADDR_W-1:0]            wb_waddr,
    input  logic [DATA_W-1:0]            wb_wdata,
    // long-latency unit
    input  logic                         lu_valid,
    input  logic [ADDR_W-1:0]            lu_waddr,
    input  logic [DATA_W-1:0]            lu_wdata,
    output logic                         lu_ready,
    // pipeline control
    output logic                         stall_req,
    // register file write port
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    // status and pending lookup
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
    input  logic [ADDR_W-1:0]            chk_addr1,
    input  logic [ADDR_W-1:0]            chk_addr2,
    output logic                         pend_hit1,
    output logic                         pend_hit2,
    output logic [DATA_W-1:0]            pend_data1,
    output logic [DATA_W-1:0]            pend_data2
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_C = STV_W'(STARVE_MAX);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_FORCE  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [STV_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic              w_empty;
    logic              w_lu_ready;
    logic              w_lu_xfer;
    logic              w_lu_nonzero;
    logic              w_wb_grant;
    logic              w_head_wr;
    logic              w_thru;
    logic              w_enq;
    logic              w_deq;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [STV_W-1:0]  w_starve_inc;

    assign w_empty      = (r_count == '0);
    assign w_lu_ready   = (r_count < DEPTH_C) && !rst;
    assign w_lu_xfer    = lu_valid && w_lu_ready;
    assign w_lu_nonzero = (lu_waddr != '0);
    assign w_head_addr  = r_mem_addr[r_rd_ptr];
    assign w_head_data  = r_mem_data[r_rd_ptr];
    assign w_starve_inc = r_starve_cnt + STV_W'(1);

    // Port selection. A FORCE cycle ignores WB entirely because the pipeline
    // is holding it frozen. The FIFO is never empty in FORCE, since entry
    // requires a non-empty FIFO whose head was not written. The emptiness
    // guard simply keeps a bubble from ever reaching the port.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_wb_grant = 1'b0;
        w_head_wr  = 1'b0;
        w_thru     = 1'b0;
        if (!rst) begin
            if (r_state == ST_FORCE) begin
                w_head_wr = !w_empty;
            end else if (wb_we && (wb_waddr != '0)) begin
                w_wb_grant = 1'b1;
            end else if (!w_empty) begin
                w_head_wr = 1'b1;
            end else if (w_lu_xfer && w_lu_nonzero) begin
                w_thru = 1'b1;
            end
        end
    end

    // An accepted LU result is buffered unless it is written straight through.
    // Results aimed at r0 are consumed here and go nowhere.
    assign w_enq = w_lu_xfer && w_lu_nonzero && !w_thru;
    assign w_deq = w_head_wr;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_wb_grant) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (w_head_wr) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_addr;
            rf_wdata = w_head_data;
        end else if (w_thru) begin
            rf_we    = 1'b1;
            rf_waddr = lu_waddr;
            rf_wdata = lu_wdata;
        end
    end

    assign lu_ready  = w_lu_ready;
    assign stall_req = (r_state == ST_FORCE);
    assign pend_cnt  = r_count;

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy, state and starvation counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples pre-edge values and there is no
        // evaluation-order race between blocks.
        if (rst) begin
            r_state      <= ST_NORMAL;
            r_starve_cnt <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            unique case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // The counter only advances while a buffered head is being denied.
            // The counter value STARVE_MAX itself is never stored. The cycle
            // that would reach it schedules FORCE instead.
            if (r_state == ST_FORCE) begin
                r_state      <= ST_NORMAL;
                r_starve_cnt <= '0;
            end else if (w_head_wr) begin
                r_starve_cnt <= '0;
            end else if (!w_empty) begin
                if (w_starve_inc == STARVE_C) begin
                    r_state      <= ST_FORCE;
                    r_starve_cnt <= '0;
                end else begin
                    r_starve_cnt <= w_starve_inc;
                end
            end
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Clearing r_count and the
        // pointers already makes every entry invalid, and nothing reads an
        // entry that is not valid.
        if (w_enq) begin
            r_mem_addr[r_wr_ptr] <= lu_waddr;
            r_mem_data[r_wr_ptr] <= lu_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Pending-result lookup
    // ------------------------------------------------------------------------
`ifdef REGWR_PEND_BYPASS_EN
    // Walks the FIFO from oldest to newest, so a later match overwrites an
    // earlier one and the youngest entry wins. r0 never matches, because a
    // read of r0 always returns zero.
    function automatic logic [DATA_W:0] f_lookup(input logic [ADDR_W-1:0] a);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PTR_W'(i);
            if ((a != '0) && (CNT_W'(i) < r_count) && (r_mem_addr[idx] == a)) begin
                hit  = 1'b1;
                data = r_mem_data[idx];
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {pend_hit1, pend_data1} = '0;
        {pend_hit2, pend_data2} = '0;
        if (!rst) begin
            {pend_hit1, pend_data1} = f_lookup(chk_addr1);
            {pend_hit2, pend_data2} = f_lookup(chk_addr2);
        end
    end
`else
    logic w_unused_chk;

    assign pend_hit1    = 1'b0;
    assign pend_hit2    = 1'b0;
    assign pend_data1   = '0;
    assign pend_data2   = '0;
    assign w_unused_chk = ^{chk_addr1, chk_addr2};
`endif

endmodule

// File: tb/tb_regwr_arbiter.sv
// ============================================================================
// tb_regwr_arbiter
// ----------------------------------------------------------------------------
// Directed scenarios with literal expectations, then a randomized run.
// A queue-based reference model of the arbiter checks every cycle's outputs.
// Inputs are driven 1 time unit after the rising edge, and outputs are
// compared on the falling edge.
// ============================================================================
module tb_regwr_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              lu_ready;
    logic              stall_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  pend_cnt;
    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic [DATA_W-1:0] pend_data1;
    logic [DATA_W-1:0] pend_data2;

    regwr_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .lu_valid  (lu_valid),
        .lu_waddr  (lu_waddr),
        .lu_wdata  (lu_wdata),
        .lu_ready  (lu_ready),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_cnt  (pend_cnt),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .pend_data1(pend_data1),
        .pend_data2(pend_data2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: FIFO contents as a queue, plus the starvation count and
    // a flag marking the upcoming cycle as a forced drain.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t m_q[$];
    bit   m_force    = 1'b0;
    int   m_starve   = 0;
    bit   m_lu_taken = 1'b0;
    bit   started    = 1'b0;

    logic              e_ready, e_stall, e_we, e_h1, e_h2;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd, e_d1, e_d2;
    int                e_cnt;
    bit                m_head_wr, m_thru, m_nonempty;

    always @(negedge clk) begin
        if (started) begin
            // expected outputs for this cycle
            e_stall    = m_force;
            e_cnt      = m_q.size();
            e_ready    = 1'b0;
            e_we       = 1'b0;
            e_wa       = '0;
            e_wd       = '0;
            e_h1       = 1'b0;
            e_d1       = '0;
            e_h2       = 1'b0;
            e_d2       = '0;
            m_lu_taken = 1'b0;
            m_head_wr  = 1'b0;
            m_thru     = 1'b0;
            m_nonempty = (m_q.size() != 0);
            if (!rst) begin
                e_ready    = (m_q.size() < DEPTH);
                m_lu_taken = lu_valid && e_ready;
                if (m_force) begin
                    m_head_wr = m_nonempty;
                end else if (wb_we && wb_waddr != 0) begin
                    e_we = 1'b1;
                    e_wa = wb_waddr;
                    e_wd = wb_wdata;
                end else if (m_nonempty) begin
                    m_head_wr = 1'b1;
                end else if (m_lu_taken && lu_waddr != 0) begin
                    m_thru = 1'b1;
                    e_we   = 1'b1;
                    e_wa   = lu_waddr;
                    e_wd   = lu_wdata;
                end
                if (m_head_wr) begin
                    e_we = 1'b1;
                    e_wa = m_q[0].a;
                    e_wd = m_q[0].d;
                end
`ifdef REGWR_PEND_BYPASS_EN
                for (int i = 0; i < m_q.size(); i++) begin
                    if (chk_addr1 != 0 && m_q[i].a == chk_addr1) begin
                        e_h1 = 1'b1;
                        e_d1 = m_q[i].d;
                    end
                    if (chk_addr2 != 0 && m_q[i].a == chk_addr2) begin
                        e_h2 = 1'b1;
                        e_d2 = m_q[i].d;
                    end
                end
`endif
            end

            check("m_lu_ready",  32'(lu_ready),  32'(e_ready));
            check("m_stall_req", 32'(stall_req), 32'(e_stall));
            check("m_rf_we",     32'(rf_we),     32'(e_we));
            if (e_we) begin
                check("m_rf_waddr", 32'(rf_waddr), 32'(e_wa));
                check("m_rf_wdata", rf_wdata, e_wd);
            end
            check("m_pend_cnt",  32'(pend_cnt),  32'(e_cnt));
            check("m_pend_hit1", 32'(pend_hit1), 32'(e_h1));
            check("m_pend_hit2", 32'(pend_hit2), 32'(e_h2));
`ifdef REGWR_PEND_BYPASS_EN
            if (e_h1) check("m_pend_data1", pend_data1, e_d1);
            if (e_h2) check("m_pend_data2", pend_data2, e_d2);
`else
            check("m_pend_data1", pend_data1, 32'd0);
            check("m_pend_data2", pend_data2, 32'd0);
`endif

            // advance the model to the next cycle
            if (rst) begin
                m_q.delete();
                m_force  = 1'b0;
                m_starve = 0;
            end else begin
                if (m_head_wr) void'(m_q.pop_front());
                if (m_lu_taken && lu_waddr != 0 && !m_thru)
                    m_q.push_back('{a: lu_waddr, d: lu_wdata});
                if (m_force) begin
                    m_force  = 1'b0;
                    m_starve = 0;
                end else if (m_head_wr) begin
                    m_starve = 0;
                end else if (m_nonempty) begin
                    m_starve++;
                    if (m_starve == STARVE_MAX) begin
                        m_force  = 1'b1;
                        m_starve = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wb_pct;

    initial begin
        rst = 1'b1;
        wb_we = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
        lu_valid = 1'b1;
        lu_waddr = 5'd9;
        lu_wdata = 32'h0BAD_0BAD;
        chk_addr1 = '0;
        chk_addr2 = '0;
        step();
        started = 1'b1;

        // Reset held two cycles with a pending LU request.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_lu_ready", 32'(lu_ready), 32'd0);
            check("rst_rf_we",    32'(rf_we),    32'd0);
            check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
            if (i == 0) step();
        end
        @(posedge clk); #1;
        rst = 1'b0;
        lu_valid = 1'b0;
        @(negedge clk);
        check("rel_lu_ready", 32'(lu_ready), 32'd1);
        step();

        // Write-through path.
        lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'h1234;
        @(negedge clk);
        check("wt_rf_we",    32'(rf_we),    32'd1);
        check("wt_rf_waddr", 32'(rf_waddr), 32'd5);
        check("wt_rf_wdata", rf_wdata,      32'h1234);
        step();
        lu_valid = 1'b0;
        @(negedge clk);
        check("wt_pend_cnt", 32'(pend_cnt), 32'd0);
        step();

        // Buffering under WB priority, then two forced drains.
        wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hDEAD_0001;
        lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'hA;            // t0
        @(negedge clk);
        check("bp_t0_rf_waddr", 32'(rf_waddr), 32'd1);
        step();
        lu_waddr = 5'd4; lu_wdata = 32'hB;                             // t1
        @(negedge clk);
        check("bp_t1_pend_cnt", 32'(pend_cnt), 32'd1);
        step();
        lu_waddr = 5'd6; lu_wdata = 32'hC;                             // t2
        @(negedge clk);
        check("bp_t2_pend_cnt", 32'(pend_cnt), 32'd2);
        check("bp_t2_lu_ready", 32'(lu_ready), 32'd0);
        step();
        for (int t = 3; t <= 4; t++) begin
            @(negedge clk);
            check("bp_pre_force_stall", 32'(stall_req), 32'd0);
            step();
        end
        @(negedge clk);                                                // t5
        check("f1_stall",    32'(stall_req), 32'd1);
        check("f1_rf_waddr", 32'(rf_waddr),  32'd3);
        check("f1_rf_wdata", rf_wdata,       32'hA);
        step();
        @(negedge clk);                                                // t6
        check("f1_stall_drop", 32'(stall_req), 32'd0);
        check("t6_lu_ready",   32'(lu_ready),  32'd1);
        step();
        lu_valid = 1'b0;
        for (int t = 7; t <= 9; t++) begin
            @(negedge clk);
            check("bp_pre_force2_stall", 32'(stall_req), 32'd0);
            step();
        end
        @(negedge clk);                                                // t10
        check("f2_stall",    32'(stall_req), 32'd1);
        check("f2_rf_waddr", 32'(rf_waddr),  32'd4);
        check("f2_rf_wdata", rf_wdata,       32'hB);
        step();
        wb_we = 1'b0;
        @(negedge clk);                                                // t11
        check("drain_rf_waddr", 32'(rf_waddr), 32'd6);
        check("drain_rf_wdata", rf_wdata,      32'hC);
        step();
        @(negedge clk);
        check("drain_pend_cnt", 32'(pend_cnt), 32'd0);
        step();

        // Register 0 from either requester.
        lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'h55;
        @(negedge clk);
        check("z_lu_rf_we",    32'(rf_we),    32'd0);
        check("z_lu_ready",    32'(lu_ready), 32'd1);
        step();
        lu_valid = 1'b0;
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h66;
        @(negedge clk);
        check("z_wb_rf_we",    32'(rf_we),    32'd0);
        check("z_lu_pend_cnt", 32'(pend_cnt), 32'd0);
        step();

        // Pending lookup with two entries for the same register.
        wb_waddr = 5'd2;
        chk_addr1 = 5'd7; chk_addr2 = 5'd0;
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h11;
        step();
        lu_wdata = 32'h22;
        step();
        lu_valid = 1'b0;
        @(negedge clk);
`ifdef REGWR_PEND_BYPASS_EN
        check("byp_hit1",  32'(pend_hit1), 32'd1);
        check("byp_data1", pend_data1,     32'h22);
`else
        check("byp_hit1_off", 32'(pend_hit1), 32'd0);
`endif
        check("byp_hit2", 32'(pend_hit2), 32'd0);
        step();
        wb_we = 1'b0;
        step();
        step();

        // Randomized run against the model.
        wb_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) wb_pct = int'($urandom_range(30, 100));
            rst = ($urandom_range(0, 299) == 0);
            if (!m_force) begin
                wb_we    = ($urandom_range(1, 100) <= wb_pct);
                wb_waddr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_wdata = $urandom;
            end
            if (!lu_valid || m_lu_taken) begin
                lu_valid = ($urandom_range(0, 2) != 0);
                lu_waddr = 5'($urandom_range(0, 7));
                lu_wdata = $urandom;
            end
            chk_addr1 = 5'($urandom_range(0, 7));
            chk_addr2 = 5'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
Name: regwr_arbiter

Overview:
- Shares the register file's single write port between two requesters.
- The pipeline writeback stage (WB) has priority and is never back-pressured.
- A long-latency unit (LU: divider, multi-cycle load) hands results over with valid/ready and is buffered in a DEPTH-entry FIFO.
- A starvation guard forces a FIFO drain by stalling the pipeline for one cycle.
- Sits between MEM/WB, the LU and the register file write port.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
DEPTH, 2, LU result FIFO entries (power of 2, >=2)
STARVE_MAX, 4, consecutive denied cycles with FIFO non-empty before a forced drain

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wb_we  in  1  WB write request
wb_waddr  in  ADDR_W  WB destination register
wb_wdata  in  DATA_W  WB data
lu_valid  in  1  LU result valid
lu_waddr  in  ADDR_W  LU destination register
lu_wdata  in  DATA_W  LU data
lu_ready  out  1  arbiter accepts LU result this cycle
stall_req  out  1  registered; pipeline must freeze WB (hold wb_* stable) while high
rf_we  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write address
rf_wdata  out  DATA_W  register file write data
pend_cnt  out  clog2(DEPTH+1)  FIFO occupancy
chk_addr1  in  ADDR_W  read port 1 address for pending lookup
chk_addr2  in  ADDR_W  read port 2 address for pending lookup
pend_hit1  out  1  pending FIFO entry matches chk_addr1
pend_hit2  out  1  pending FIFO entry matches chk_addr2
pend_data1  out  DATA_W  newest matching FIFO data for port 1
pend_data2  out  DATA_W  newest matching FIFO data for port 2

Behaviour:
- Reset: clk and rst as named; reset is synchronous, active-high (rst==1 sampled at posedge clk).
  - All outputs 0 on reset except lu_ready, which is 1 one cycle after reset releases.
  - FIFO emptied, starve_cnt=0, state=NORMAL.
  - Reset mid-operation discards all buffered LU results.
- LU handshake:
  - lu_ready = (count<DEPTH) && !rst, combinational from registered count.
  - Transfer occurs when lu_valid && lu_ready.
  - LU holds lu_* stable until the transfer occurs.
  - When full, lu_ready=0; there is no full-cycle pass-through.
- Zero register:
  - An accepted LU result with lu_waddr==0 is consumed and discarded (not enqueued, not written).
  - rf_we is never asserted with rf_waddr==0.
- Write port selection is combinational, same cycle as the request.
- State NORMAL, in priority order:
  1. wb_we && wb_waddr!=0 -> grant WB.
  2. Else, FIFO non-empty -> write FIFO head and dequeue.
  3. Else, FIFO empty && LU transfer -> write-through LU directly (not enqueued).
  4. Else, rf_we=0.
- Enqueue and dequeue in the same cycle leave count unchanged; FIFO order is preserved.
- Starve counter:
  - starve_cnt increments each NORMAL cycle the FIFO is non-empty and its head is not written.
  - It clears on any head write.
  - When it would reach STARVE_MAX, the next state is FORCE.
- State FORCE (exactly one cycle):
  - stall_req=1; wb_* ignored (WB held by pipeline); FIFO head written and dequeued.
  - LU may still enqueue if lu_ready.
  - Next state NORMAL, starve_cnt=0, stall_req=0.
- Ordering: WB-vs-LU same-destination hazards are prevented by issue-stage scoreboarding and are not checked here.
- Write latency: WB 0 cycles; LU at most (DEPTH)*(STARVE_MAX+1) cycles after acceptance.

Optional Feature:
- Macro: REGWR_PEND_BYPASS_EN.
- Defined:
  - pend_hitN=1 when any valid FIFO entry has waddr==chk_addrN and chk_addrN!=0.
  - pend_dataN = data of the newest such entry (youngest wins); combinational.
  - Used by the decode stage to forward results not yet in the regfile.
- Undefined: pend_hit1/2 and pend_data1/2 tied to 0; no comparators synthesized.

Test Plan:
- Reset: hold rst=1 two cycles with lu_valid=1 -> lu_ready=0, rf_we=0, pend_cnt=0; first cycle after release lu_ready=1.
- Write-through: FIFO empty, wb_we=0, LU valid waddr=5 data=0x1234 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 same cycle; pend_cnt stays 0.
- Buffer and priority: wb_we=1 every cycle; LU sends r3=0xA then r4=0xB -> both enqueued, pend_cnt=2, lu_ready=0; third LU result waits.
- Starvation guard: continue wb_we=1 -> after 4 denied cycles, stall_req=1 for one cycle with rf_waddr=3/0xA; stall_req drops, and 4 cycles later a second FORCE writes r4/0xB.
- Zero register: LU waddr=0 accepted -> no rf_we, pend_cnt unchanged; WB waddr=0 -> rf_we=0.
- Bypass (macro on): FIFO holds r7=0x11 then r7=0x22, chk_addr1=7 -> pend_hit1=1, pend_data1=0x22; chk_addr2=0 -> pend_hit2=0. With macro off, both hits read 0.
